// File: rtl/lif_step_scheduler.sv
// lif_step_scheduler
//   Time-multiplexed controller for N_NEURONS leaky integrate-and-fire
//   neurons sharing one update datapath. A step request walks every neuron
//   once (one neuron per cycle): leak, integrate programmed current with
//   saturation, threshold/fire, then publish the spike vector with a
//   one-cycle done pulse.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   step_in         request one timestep (accepted in IDLE or DONE)
//   wr_en/wr_addr/wr_data   write input-current register cur[wr_addr]
//   threshold       firing threshold, latched at step acceptance
//   leak_shift      leak shift, latched at step acceptance
//   mem_sel/mem_out combinational membrane readout
//   busy            high while neurons are being updated
//   done            one-cycle pulse when a step completes
//   spikes          spike vector of the last completed step
//   step_count      completed-step counter (wraps)
module lif_step_scheduler #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned WIDTH     = 8,
    localparam int unsigned AW       = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_in,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH-1:0]     threshold,
    input  logic [2:0]           leak_shift,
    input  logic [AW-1:0]        mem_sel,
    output logic [WIDTH-1:0]     mem_out,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes,
    output logic [7:0]           step_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]     mem_q [N_NEURONS];
    logic [WIDTH-1:0]     mem_d [N_NEURONS];
    logic [WIDTH-1:0]     cur_q [N_NEURONS];
    logic [WIDTH-1:0]     cur_d [N_NEURONS];
    logic [AW-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]     thr_q, thr_d;
    logic [2:0]           sh_q, sh_d;
    logic [N_NEURONS-1:0] acc_q, acc_d;
    logic [N_NEURONS-1:0] spikes_q, spikes_d;
    logic [7:0]           cnt_q, cnt_d;

    logic                 accept;
    logic                 last;

    // Shared neuron datapath
    logic [WIDTH-1:0]     cur_mem;
    logic [WIDTH-1:0]     decayed;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     sat_sum;
    logic                 fire;

    assign last = (idx_q == AW'(N_NEURONS - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (step_in) state_d = S_UPDATE;
            S_UPDATE: if (last)    state_d = S_DONE;
            S_DONE:   state_d = step_in ? S_UPDATE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy   = (state_q == S_UPDATE);
        done   = (state_q == S_DONE);
        // step_in during UPDATE is dropped, not queued
        accept = step_in && (state_q != S_UPDATE);
    end

    // ------------------------------------------------------------------
    // Neuron update for the neuron at idx_q
    // ------------------------------------------------------------------
    always_comb begin
        cur_mem = mem_q[idx_q];
        // With sh_q == 0 the shift is a no-op, so decayed collapses to 0.
        decayed = cur_mem - (cur_mem >> sh_q);
        sum     = {1'b0, decayed} + {1'b0, cur_q[idx_q]};
        sat_sum = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        fire    = (sat_sum >= thr_q);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        cur_d    = cur_q;
        idx_d    = idx_q;
        thr_d    = thr_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        spikes_d = spikes_q;
        cnt_d    = cnt_q;

        // The update reads cur_q, so a write landing on the neuron being
        // updated at the same edge only takes effect next step.
        if (wr_en) begin
            cur_d[wr_addr] = wr_data;
        end

        if (accept) begin
            idx_d = '0;
            thr_d = threshold;
            sh_d  = leak_shift;
            acc_d = '0;
        end else if (state_q == S_UPDATE) begin
            mem_d[idx_q] = fire ? '0 : sat_sum;
            acc_d[idx_q] = fire;
            if (last) begin
                // Publish including the bit computed this cycle.
                spikes_d = acc_d;
                cnt_d    = cnt_q + 8'd1;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            cur_q    <= '{default: '0};
            idx_q    <= '0;
            thr_q    <= '0;
            sh_q     <= '0;
            acc_q    <= '0;
            spikes_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            cur_q    <= cur_d;
            idx_q    <= idx_d;
            thr_q    <= thr_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            spikes_q <= spikes_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_out    = mem_q[mem_sel];
    assign spikes     = spikes_q;
    assign step_count = cnt_q;

endmodule

// File: tb/tb_lif_step_scheduler.sv
module tb_lif_step_scheduler;

    logic       clk;
    logic       rst_n;
    logic       step_in;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] threshold;
    logic [2:0] leak_shift;
    logic [1:0] mem_sel;
    logic [7:0] mem_out;
    logic       busy;
    logic       done;
    logic [3:0] spikes;
    logic [7:0] step_count;

    int tests = 0;
    int fails = 0;

    // Reference model
    int m_mem [4];
    int m_cur [4];
    int m_spk;
    int m_cnt;

    lif_step_scheduler #(.N_NEURONS(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .step_in(step_in), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .threshold(threshold),
        .leak_shift(leak_shift), .mem_sel(mem_sel), .mem_out(mem_out),
        .busy(busy), .done(done), .spikes(spikes), .step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mem[i] = 0;
            m_cur[i] = 0;
        end
        m_spk = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_step(input int thr, input int sh);
        int spk = 0;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = m_mem[i] - (m_mem[i] >> sh) + m_cur[i];
            if (s > 255) s = 255;
            if (s >= thr) begin
                spk = spk | (1 << i);
                m_mem[i] = 0;
            end else begin
                m_mem[i] = s;
            end
        end
        m_spk = spk;
        m_cnt = (m_cnt + 1) % 256;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; step_in = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic write_cur(input int i, input int v);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'(i); wr_data = 8'(v);
        @(negedge clk);
        wr_en = 1'b0;
        m_cur[i] = v;
    endtask

    function automatic int read_mem(input int i);
        mem_sel = 2'(i);
        return 0;
    endfunction

    task automatic get_mem(input int i, output int v);
        mem_sel = 2'(i);
        #1;
        v = int'(mem_out);
    endtask

    // Returns at the negedge where done is high; mid_thr >= 0 changes the
    // threshold input while the step is in progress.
    task automatic do_step(input int thr, input int sh, input int mid_thr);
        int n;
        @(negedge clk);
        step_in = 1'b1; threshold = 8'(thr); leak_shift = 3'(sh);
        @(negedge clk);
        step_in = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            if (n == 2 && mid_thr >= 0) threshold = 8'(mid_thr);
            @(negedge clk);
            n++;
        end
        if (!done) check("step_timeout", 0, 1);
        model_step(thr, sh);
    endtask

    task automatic check_model(input string tag);
        int v;
        check({tag, "_spikes"}, int'(spikes), m_spk);
        check({tag, "_count"}, int'(step_count), m_cnt);
        for (int i = 0; i < 4; i++) begin
            get_mem(i, v);
            check($sformatf("%s_mem%0d", tag, i), v, m_mem[i]);
        end
    endtask

    typedef struct {
        int wr_idx;   // -1: no write
        int wr_val;
        int thr;
        int sh;
        int exp_spk;
        int sel;
        int exp_mem;
        int exp_cnt;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int v, busy_cnt, done_cnt, done_at, last_at, overlap, consec, cnt0;
        logic prev_done;

        rst_n = 1'b0; step_in = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; threshold = '0; leak_shift = '0; mem_sel = '0;

        // LIF accumulation, saturation and threshold-zero vectors
        tbl[0] = '{0,   60, 100, 1, 4'b0000, 0,  60, 1};
        tbl[1] = '{-1,   0, 100, 1, 4'b0000, 0,  90, 2};
        tbl[2] = '{-1,   0, 100, 1, 4'b0001, 0,   0, 3};
        tbl[3] = '{1,  250, 255, 4, 4'b0000, 1, 250, 4};
        tbl[4] = '{-1,   0, 255, 4, 4'b0010, 1,   0, 5};
        tbl[5] = '{-1,   0,   0, 3, 4'b1111, 2,   0, 6};

        do_reset();
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_spikes", int'(spikes), 0);
        check("rst_count", int'(step_count), 0);
        for (int i = 0; i < 4; i++) begin
            get_mem(i, v);
            check($sformatf("rst_mem%0d", i), v, 0);
        end

        for (int t = 0; t < 6; t++) begin
            if (tbl[t].wr_idx >= 0) write_cur(tbl[t].wr_idx, tbl[t].wr_val);
            do_step(tbl[t].thr, tbl[t].sh, -1);
            check($sformatf("tbl%0d_spikes", t), int'(spikes), tbl[t].exp_spk);
            check($sformatf("tbl%0d_count", t), int'(step_count), tbl[t].exp_cnt);
            get_mem(tbl[t].sel, v);
            check($sformatf("tbl%0d_mem", t), v, tbl[t].exp_mem);
        end
        check_model("tbl_end");

        // Single-pulse timing, step_in during busy ignored
        @(negedge clk);
        cnt0 = int'(step_count);
        step_in = 1'b1; threshold = 8'd200; leak_shift = 3'd2;
        @(negedge clk);
        step_in = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = 0; overlap = 0; consec = 0;
        prev_done = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (busy && done) overlap++;
            if (done && prev_done) consec++;
            prev_done = done;
            step_in = (k == 2 || k == 3);
            @(negedge clk);
        end
        step_in = 1'b0;
        model_step(200, 2);
        check("tim_busy_cycles", busy_cnt, 4);
        check("tim_done_cycles", done_cnt, 1);
        check("tim_done_pos", done_at, 5);
        check("tim_overlap", overlap, 0);
        check("tim_count_delta", (int'(step_count) - cnt0 + 256) % 256, 1);
        check_model("tim");

        // Back-to-back with step_in held for 20 cycles
        @(negedge clk);
        cnt0 = int'(step_count);
        step_in = 1'b1; threshold = 8'd150; leak_shift = 3'd1;
        done_cnt = 0; done_at = 0; last_at = 0; consec = 0; prev_done = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
                last_at = k;
            end
            if (done && prev_done) consec++;
            prev_done = done;
        end
        step_in = 1'b0;
        for (int s = 0; s < 4; s++) model_step(150, 1);
        check("b2b_done_cnt", done_cnt, 4);
        check("b2b_first_done", done_at, 5);
        check("b2b_last_done", last_at, 20);
        check("b2b_consec_done", consec, 0);
        check("b2b_count_delta", (int'(step_count) - cnt0 + 256) % 256, 4);
        check_model("b2b");

        // Write collision on neuron 2 plus a mid-step threshold change
        do_reset();
        write_cur(2, 10);
        @(negedge clk);
        step_in = 1'b1; threshold = 8'd255; leak_shift = 3'd0;
        @(negedge clk);          // after E0
        step_in = 1'b0;
        @(negedge clk);          // after E1
        @(negedge clk);          // after E2: write lands at E3 with neuron 2
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'd50;
        @(negedge clk);
        wr_en = 1'b0;
        for (int n = 0; n < 5 && !done; n++) @(negedge clk);
        check("col_done_seen", int'(done), 1);
        get_mem(2, v);
        check("col_step1_mem2", v, 10);
        check("col_step1_spikes", int'(spikes), 0);
        model_step(255, 0);
        m_cur[2] = 50;
        do_step(255, 0, -1);
        get_mem(2, v);
        check("col_step2_mem2", v, 50);
        do_step(255, 0, 0);
        check("thr_mid_spikes", int'(spikes), 0);
        do_step(0, 0, -1);
        check("thr_next_spikes", int'(spikes), 4'b1111);
        check_model("col");

        // Asynchronous reset in the middle of an update
        write_cur(1, 33);
        do_step(0, 0, -1);
        @(negedge clk);
        step_in = 1'b1; threshold = 8'd255; leak_shift = 3'd1;
        @(negedge clk);
        step_in = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_spikes", int'(spikes), 0);
        check("arst_count", int'(step_count), 0);
        get_mem(0, v);
        check("arst_mem0", v, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("arst_no_done", done_cnt, 0);
        write_cur(0, 7);
        do_step(255, 1, -1);
        check_model("arst_after");

        // Randomized steps against the model
        for (int r = 0; r < 40; r++) begin
            int nw, thr, sel;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                write_cur($urandom_range(0, 3), $urandom_range(0, 255));
            sel = $urandom_range(0, 9);
            thr = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(1, 254);
            do_step(thr, $urandom_range(0, 7), -1);
            check_model($sformatf("rnd%0d", r));
        end

        // step_count wraps 255 -> 0
        do_reset();
        for (int s = 0; s < 255; s++) do_step(255, 0, -1);
        check("wrap_255", int'(step_count), 255);
        do_step(255, 0, -1);
        check("wrap_0", int'(step_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
